button_conditioner: RTL and testbench

- Per-button input conditioning stage that sits directly upstream of the stove core.
- Takes one raw, bouncy, asynchronous push-button and produces the single-cycle event pulses the stove consumes: press, release, auto-repeat and long-press.
- Combines synchronising, debouncing, edge detection, hold-to-repeat and the 3-second hold timing in one reusable block.
- Replaces ad-hoc edge/timer wiring; one instance per button (inc, dec, power, surface).

---
 rtl/stove_pkg.sv | 20 ++
 rtl/sync_debounce_core.sv | 51 +++++
 rtl/button_conditioner.sv | 142 ++++++++++++++
 tb/tb_button_conditioner.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stove_pkg.sv
// Shared types and 50 MHz timing defaults for the stove
// front-panel input path.
package stove_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD_DELAY,
    HOLD_REPEAT
  } btn_state_t;

  localparam int DEBOUNCE_20MS       = 1_000_000;
  localparam int REPEAT_DELAY_500MS  = 25_000_000;
  localparam int REPEAT_PERIOD_200MS = 10_000_000;
  localparam int LONG_3S             = 150_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_debounce_core.sv
// Two-flop synchroniser and stable-count debouncer for one raw
// button; strobes fire on the edge that flips the held level.
module sync_debounce_core
  import stove_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS
) (
  input  logic clk,
  input  logic async_reset,
  input  logic i_sig,
  output logic o_held,
  output logic o_rise,
  output logic o_fall
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_held;
  logic [DW-1:0] r_cnt;
  logic          w_flip;

  assign w_flip = (r_s2 != r_held) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_held <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      if (r_s2 == r_held) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_held <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  assign o_held = r_held;
  assign o_rise = w_flip & r_s2;
  assign o_fall = w_flip & ~r_s2;

endmodule

// File: rtl/button_conditioner.sv
// Per-button conditioner: debounced level plus press, release,
// auto-repeat and long-press pulses for the stove core.
module button_conditioner
  import stove_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_200MS,
  parameter int LONG_CYCLES     = LONG_3S
) (
  input  logic clk,
  input  logic async_reset,
  input  logic signal_input,
  input  logic repeat_enable,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic long_press
);

  localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = $clog2(RMAX + 1);
  localparam int LW   = $clog2(LONG_CYCLES + 1);

  btn_state_t    r_state;
  btn_state_t    w_state_nxt;
  logic [RW-1:0] r_rep_cnt;
  logic [RW-1:0] w_rep_nxt;
  logic [LW-1:0] r_hold_cnt;
  logic [LW-1:0] w_hold_nxt;
  logic          r_press;
  logic          r_release;
  logic          r_repeat;
  logic          r_long;
  logic          w_repeat_nxt;
  logic          w_long_nxt;
  logic          w_held;
  logic          w_rise;
  logic          w_fall;
  logic          w_delay_due;
  logic          w_period_due;
  logic          w_hold_sat;

  sync_debounce_core #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_core (
    .clk        (clk),
    .async_reset(async_reset),
    .i_sig      (signal_input),
    .o_held     (w_held),
    .o_rise     (w_rise),
    .o_fall     (w_fall)
  );

  // "due" means the count reaches its target on this edge
  assign w_delay_due  = (int'(r_rep_cnt) + 1) >= REPEAT_DELAY;
  assign w_period_due = (int'(r_rep_cnt) + 1) >= REPEAT_PERIOD;
  assign w_hold_sat   = int'(r_hold_cnt) == LONG_CYCLES;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state    <= IDLE;
      r_rep_cnt  <= '0;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
      r_long     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_press    <= w_rise;
      r_release  <= w_fall;
      r_repeat   <= w_repeat_nxt;
      r_long     <= w_long_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rep_nxt    = r_rep_cnt;
    w_hold_nxt   = r_hold_cnt;
    w_repeat_nxt = 1'b0;
    w_long_nxt   = 1'b0;

    if (w_fall) begin
      w_state_nxt = IDLE;
      w_rep_nxt   = '0;
      w_hold_nxt  = '0;
    end else begin
      if (r_state != IDLE && !w_hold_sat) begin
        w_hold_nxt = r_hold_cnt + LW'(1);
        w_long_nxt = (int'(r_hold_cnt) + 1) == LONG_CYCLES;
      end

      unique case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_state_nxt = HOLD_DELAY;
            w_rep_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end
        HOLD_DELAY: begin
          if (!w_delay_due) begin
            w_rep_nxt = r_rep_cnt + RW'(1);
          end else if (repeat_enable) begin
            w_repeat_nxt = 1'b1;
            w_rep_nxt    = '0;
            w_state_nxt  = HOLD_REPEAT;
          end else begin
            w_rep_nxt = RW'(REPEAT_DELAY);
          end
        end
        HOLD_REPEAT: begin
          if (!w_period_due) begin
            w_rep_nxt = r_rep_cnt + RW'(1);
          end else if (repeat_enable) begin
            w_repeat_nxt = 1'b1;
            w_rep_nxt    = '0;
          end else begin
            w_rep_nxt = RW'(REPEAT_PERIOD);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rep_nxt   = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign held          = w_held;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign repeat_pulse  = r_repeat;
  assign long_press    = r_long;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulse events (kind, cycle) are queued
// at stimulus time and matched as the DUT emits pulses.
module tb_button_conditioner;
  import stove_pkg::*;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LC  = 50;
  localparam int LAT = DEB + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic raw   = 1'b0;
  logic en    = 1'b0;
  logic held;
  logic press;
  logic rel;
  logic rep;
  logic lng;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk          (clk),
    .async_reset  (rst_n),
    .signal_input (raw),
    .repeat_enable(en),
    .held         (held),
    .press_pulse  (press),
    .release_pulse(rel),
    .repeat_pulse (rep),
    .long_press   (lng)
  );

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  n_vec = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // kinds: 0 press, 1 release, 2 repeat, 3 long
  task automatic push_ev(input int kind, input int c);
    ev_t e;
    int  idx;
    bit  found;
    e.kind = kind;
    e.cyc  = c;
    idx    = q.size();
    found  = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (!found && (q[i].cyc * 4 + q[i].kind > c * 4 + kind)) begin
        idx   = i;
        found = 1'b1;
      end
    end
    q.insert(idx, e);
  endtask

  always @(negedge clk) begin
    logic [3:0] p;
    ev_t        e;
    p = {lng, rep, rel, press};
    for (int k = 0; k < 4; k++) begin
      if (p[k]) begin
        if (q.size() == 0) begin
          chk($sformatf("extra_k%0d_c%0d", k, cyc), int'(p[k]), 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("kind_c%0d", cyc), k, e.kind);
          chk($sformatf("cyc_k%0d", k), cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_press(output int p);
    @(negedge clk);
    raw = 1'b1;
    p   = cyc + LAT;
    push_ev(0, p);
  endtask

  task automatic hold_release(input int p, input int len);
    if (en) begin
      for (int k = RD; k < len; k += RP) push_ev(2, p + k);
    end
    if (LC < len) push_ev(3, p + LC);
    push_ev(1, p + len);
    wait_until(p);
    chk("held_hi", int'(held), 1);
    wait_until(p + len - LAT);
    raw = 1'b0;
    wait_until(p + len);
    chk("held_lo", int'(held), 0);
    wait_until(p + len + 12);
    chk("q_drain", q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_held"}, int'(held), 0);
    chk({tag, "_press"}, int'(press), 0);
    chk({tag, "_rel"}, int'(rel), 0);
    chk({tag, "_rep"}, int'(rep), 0);
    chk({tag, "_long"}, int'(lng), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    int p2;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // clean short press: press then release only
    en = 1'b1;
    start_press(p);
    hold_release(p, 16);

    // 3-cycle glitch never reaches held
    @(negedge clk);
    raw = 1'b1;
    repeat (3) @(negedge clk);
    raw = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_held", int'(held), 0);
    chk("glitch_q", q.size(), 0);

    // long hold with repeat
    en = 1'b1;
    start_press(p);
    hold_release(p, 70);

    // long hold without repeat
    en = 1'b0;
    start_press(p);
    hold_release(p, 70);

    // early release
    en = 1'b1;
    start_press(p);
    hold_release(p, 30);
    chk("idle", int'(dut.r_state), int'(IDLE));

    // reset mid-hold with the raw input still high
    en = 1'b1;
    start_press(p);
    push_ev(2, p + RD);
    push_ev(2, p + RD + RP);
    push_ev(2, p + RD + 2 * RP);
    wait_until(p);
    chk("held_hi6", int'(held), 1);
    wait_until(p + 40);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    chk("q_rst", q.size(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p2 = cyc + LAT;
    push_ev(0, p2);
    hold_release(p2, 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
